// File: rtl/tdm_lane_packer.sv
// Purpose : re-pairs the interleaved slot-0/slot-1 TDM byte stream into
//           {lane0, lane1} words and buffers them in a small FWFT FIFO.
// Latency : 1 cycle from slot-1 byte accepted to word on dout (FIFO empty).
// Backpressure: dout_ready stalls the FIFO; a completed pair arriving while
//           the FIFO is full with no pop is dropped and counted in drop_cnt.
//
// Ports:
//   clk, rst             clk200m TDM clock, async active-high reset
//   din_valid/din/din_slot  incoming TDM byte and its slot tag
//   dout_valid/dout_ready/dout  FWFT word output, lane 0 in the MSBs
//   fill_level           words currently buffered (0..FIFO_DEPTH)
//   seq_err_cnt          saturating count of out-of-sequence slot bytes
//   drop_cnt             saturating count of words lost to overflow
module tdm_lane_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          din_valid,
    input  logic [DATA_WIDTH-1:0]         din,
    input  logic                          din_slot,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic [2*DATA_WIDTH-1:0]       dout,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic [CNT_WIDTH-1:0]          seq_err_cnt,
    output logic [CNT_WIDTH-1:0]          drop_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int WW = 2 * DATA_WIDTH;

    typedef enum logic {
        EXPECT_S0 = 1'b0,
        EXPECT_S1 = 1'b1
    } state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] hold, hold_nxt;
    logic                  pair_done;
    logic                  seq_err;

    logic [WW-1:0]         mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [LW-1:0]         fill;
    logic [WW-1:0]         last_dout;
    logic                  fifo_empty, fifo_full;
    logic                  pop, push_ok, drop;

    // ------------------------------------------------------------------
    // Pairing FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EXPECT_S0;
            hold  <= '0;
        end else begin
            state <= state_nxt;
            hold  <= hold_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold;
        pair_done = 1'b0;
        seq_err   = 1'b0;
        if (din_valid) begin
            case (state)
                EXPECT_S0: begin
                    if (!din_slot) begin
                        hold_nxt  = din;
                        state_nxt = EXPECT_S1;
                    end else begin
                        // orphan slot-1 byte: nothing to pair it with
                        seq_err = 1'b1;
                    end
                end
                EXPECT_S1: begin
                    if (din_slot) begin
                        pair_done = 1'b1;
                        state_nxt = EXPECT_S0;
                    end else begin
                        // resynchronise on the newest slot-0 byte
                        seq_err  = 1'b1;
                        hold_nxt = din;
                    end
                end
                default: state_nxt = EXPECT_S0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Word FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    assign fifo_empty = (fill == '0);
    assign fifo_full  = (fill == LW'(FIFO_DEPTH));
    assign pop        = !fifo_empty && dout_ready;
    // a same-cycle pop frees the head slot, so a full FIFO still accepts
    assign push_ok    = pair_done && (!fifo_full || pop);
    assign drop       = pair_done && fifo_full && !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fill      <= '0;
            last_dout <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= {hold, din};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                last_dout <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   fill <= fill + LW'(1);
                2'b01:   fill <= fill - LW'(1);
                default: fill <= fill;
            endcase
        end
    end

    // once drained, dout keeps showing the last word handed out
    assign dout       = fifo_empty ? last_dout : mem[rd_ptr];
    assign dout_valid = !fifo_empty;
    assign fill_level = fill;

    // ------------------------------------------------------------------
    // Saturating error / drop counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_err_cnt <= '0;
            drop_cnt    <= '0;
        end else begin
            if (seq_err && (seq_err_cnt != '1)) begin
                seq_err_cnt <= seq_err_cnt + CNT_WIDTH'(1);
            end
            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_tdm_lane_packer.sv
// Purpose : self-checking bench for tdm_lane_packer (table vectors,
//           hand-written corner sequences, randomized stream vs. model).
// Latency : n/a. Backpressure: dout_ready driven by the bench.
module tb_tdm_lane_packer;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            din_valid = 1'b0;
    logic [DW-1:0]   din = '0;
    logic            din_slot = 1'b0;
    logic            dout_valid;
    logic            dout_ready = 1'b0;
    logic [2*DW-1:0] dout;
    logic [2:0]      fill_level;
    logic [CW-1:0]   seq_err_cnt;
    logic [CW-1:0]   drop_cnt;

    int total = 0;
    int bad   = 0;

    tdm_lane_packer #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .din_valid   (din_valid),
        .din         (din),
        .din_slot    (din_slot),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .dout        (dout),
        .fill_level  (fill_level),
        .seq_err_cnt (seq_err_cnt),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    bit              m_have;      // a slot-0 byte is waiting for its partner
    logic [DW-1:0]   m_hold;
    logic [2*DW-1:0] m_q[$];
    int              m_seq;
    int              m_drop;
    logic [2*DW-1:0] m_last;

    function automatic void model_reset();
        m_have = 0;
        m_hold = '0;
        m_q.delete();
        m_seq  = 0;
        m_drop = 0;
        m_last = '0;
    endfunction

    function automatic void model_step(bit v, logic [DW-1:0] d, bit s, bit r);
        if (r && m_q.size() > 0) void'(m_q.pop_front());
        if (v) begin
            if (!s) begin
                if (m_have) m_seq = (m_seq < 255) ? m_seq + 1 : 255;
                m_hold = d;
                m_have = 1;
            end else if (m_have) begin
                if (m_q.size() < DEPTH) m_q.push_back({m_hold, d});
                else m_drop = (m_drop < 255) ? m_drop + 1 : 255;
                m_have = 0;
            end else begin
                m_seq = (m_seq < 255) ? m_seq + 1 : 255;
            end
        end
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic chk_model();
        logic [2*DW-1:0] exp_dout;
        exp_dout = (m_q.size() > 0) ? m_q[0] : m_last;
        chk("model_valid", 32'(dout_valid), 32'(m_q.size() > 0));
        chk("model_fill", 32'(fill_level), 32'(m_q.size()));
        chk("model_dout", 32'(dout), 32'(exp_dout));
        chk("model_seq", 32'(seq_err_cnt), 32'(m_seq));
        chk("model_drop", 32'(drop_cnt), 32'(m_drop));
        if (m_q.size() > 0) m_last = m_q[0];
    endtask

    // drive one cycle of inputs, clock it, then check against the model
    task automatic cyc(bit v, logic [DW-1:0] d, bit s, bit r);
        din_valid  = v;
        din        = d;
        din_slot   = s;
        dout_ready = r;
        @(posedge clk);
        #1;
        model_step(v, d, s, r);
        chk_model();
    endtask

    task automatic do_reset();
        din_valid  = 0;
        dout_ready = 0;
        rst        = 1;
        #2;
        chk("rst_valid", 32'(dout_valid), 0);
        chk("rst_fill", 32'(fill_level), 0);
        chk("rst_dout", 32'(dout), 0);
        chk("rst_seq", 32'(seq_err_cnt), 0);
        chk("rst_drop", 32'(drop_cnt), 0);
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
    endtask

    typedef struct {
        bit              v;
        logic [DW-1:0]   d;
        bit              s;
        bit              r;
        bit              ev;
        logic [2*DW-1:0] edout;
        logic [2:0]      efill;
        logic [CW-1:0]   eseq;
        logic [CW-1:0]   edrop;
    } vec_t;

    vec_t tbl[10];

    initial begin
        tbl[0] = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd0, 8'd0, 8'd0};
        tbl[1] = '{1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 16'h1122, 3'd1, 8'd0, 8'd0};
        tbl[2] = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 16'h1122, 3'd0, 8'd0, 8'd0};
        tbl[3] = '{1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 16'h3344, 3'd1, 8'd0, 8'd0};
        tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'h3344, 3'd0, 8'd0, 8'd0};
        tbl[5] = '{1'b1, 8'hAA, 1'b1, 1'b1, 1'b0, 16'h3344, 3'd0, 8'd1, 8'd0};
        tbl[6] = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 16'h3344, 3'd0, 8'd1, 8'd0};
        tbl[7] = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 16'h3344, 3'd0, 8'd2, 8'd0};
        tbl[8] = '{1'b1, 8'h03, 1'b1, 1'b1, 1'b1, 16'h0203, 3'd1, 8'd2, 8'd0};
        tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0203, 3'd0, 8'd2, 8'd0};

        do_reset();

        // basic pairing and sequence-error vectors
        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].v, tbl[i].d, tbl[i].s, tbl[i].r);
            chk($sformatf("tbl%0d_valid", i), 32'(dout_valid), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_dout", i), 32'(dout), 32'(tbl[i].edout));
            chk($sformatf("tbl%0d_fill", i), 32'(fill_level), 32'(tbl[i].efill));
            chk($sformatf("tbl%0d_seq", i), 32'(seq_err_cnt), 32'(tbl[i].eseq));
            chk($sformatf("tbl%0d_drop", i), 32'(drop_cnt), 32'(tbl[i].edrop));
        end

        // overflow: five pairs into a depth-4 FIFO with no consumer
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            cyc(1, 8'(i), 0, 0);
            cyc(1, 8'(i), 1, 0);
        end
        chk("ovf_fill", 32'(fill_level), 4);
        chk("ovf_drop", 32'(drop_cnt), 1);
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("ovf_pop%0d", k), 32'(dout), 32'({8'(k), 8'(k)}));
            cyc(0, 0, 0, 1);
        end
        chk("ovf_empty", 32'(dout_valid), 0);

        // full FIFO, pair completes in the same cycle as a pop
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            cyc(1, 8'(8'h10 * i), 0, 0);
            cyc(1, 8'(8'h10 * i + 1), 1, 0);
        end
        chk("fullpop_pre_fill", 32'(fill_level), 4);
        cyc(1, 8'h50, 0, 0);
        cyc(1, 8'h51, 1, 1);
        chk("fullpop_fill", 32'(fill_level), 4);
        chk("fullpop_drop", 32'(drop_cnt), 0);
        chk("fullpop_head", 32'(dout), 32'h2021);
        for (int k = 0; k < 4; k++) cyc(0, 0, 0, 1);
        chk("fullpop_last", 32'(dout), 32'h5051);

        // reset mid-pair discards the held byte
        do_reset();
        cyc(1, 8'h99, 1, 1);
        chk("midrst_seq_pre", 32'(seq_err_cnt), 1);
        cyc(1, 8'h55, 0, 1);
        do_reset();
        cyc(1, 8'h66, 0, 1);
        cyc(1, 8'h77, 1, 1);
        chk("midrst_word", 32'(dout), 32'h6677);
        chk("midrst_valid", 32'(dout_valid), 1);

        // sequence-error counter saturation
        do_reset();
        for (int i = 0; i < 300; i++) cyc(1, 8'(i), 1, 1);
        chk("sat_seq", 32'(seq_err_cnt), 255);
        chk("sat_valid", 32'(dout_valid), 0);

        // randomized stream against the model
        do_reset();
        begin
            bit nxt_slot;
            int rdy_pct;
            nxt_slot = 0;
            for (int i = 0; i < 3000; i++) begin
                bit v, s, r;
                rdy_pct = ((i / 500) % 3 == 0) ? 90 : ((i / 500) % 3 == 1) ? 30 : 60;
                v = ($urandom_range(0, 99) < 80);
                s = ($urandom_range(0, 99) < 88) ? nxt_slot : !nxt_slot;
                r = ($urandom_range(0, 99) < rdy_pct);
                if (v) nxt_slot = !s;
                cyc(v, 8'($urandom), s, r);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
